// File: rtl/mmio_fifo_pkg.sv
// Shared constants and types for the MMIO FIFO controller.
package mmio_fifo_pkg;

  // Default register map
  localparam logic [15:0] DefaultDataAddr   = 16'h0020;
  localparam logic [15:0] DefaultStatusAddr = 16'h0022;
  localparam logic [15:0] DefaultCtrlAddr   = 16'h0024;
  localparam logic [15:0] StatsAddr         = 16'h0026;

  // STATUS word layout
  localparam int unsigned StatusCountLsb = 0;
  localparam int unsigned StatusEmptyBit = 16;
  localparam int unsigned StatusFullBit  = 17;
  localparam int unsigned StatusOvfBit   = 18;
  localparam int unsigned StatusUnfBit   = 19;
  localparam int unsigned StatusDepthLsb = 32;

  // CTRL word layout
  localparam int unsigned CtrlFlushBit = 0;
  localparam int unsigned CtrlClearBit = 1;

  typedef logic [8:0] t_mmio_tid;

endpackage

// File: rtl/mmio_fifo_ram.sv
// DEPTH x 64 storage: one registered write port, combinational read.
module mmio_fifo_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PtrW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [PtrW-1:0] waddr,
  input  logic [63:0]     wdata,
  input  logic [PtrW-1:0] raddr,
  output logic [63:0]     rdata
);

  logic [63:0] mem_q [DEPTH];

  // Store a word on an accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO-facing controller for a circular 64-bit FIFO.
// Optional MMIO_FIFO_STATS_EN adds push/pop counters readable at StatsAddr.
module mmio_fifo_ctrl
  import mmio_fifo_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter logic [15:0] DATA_ADDR   = DefaultDataAddr,
  parameter logic [15:0] STATUS_ADDR = DefaultStatusAddr,
  parameter logic [15:0] CTRL_ADDR   = DefaultCtrlAddr
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mmio_wr_valid,
  input  logic [15:0] mmio_wr_addr,
  input  logic [63:0] mmio_wr_data,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_rd_addr,
  input  t_mmio_tid   mmio_rd_tid,
  output logic        rsp_valid,
  output t_mmio_tid   rsp_tid,
  output logic [63:0] rsp_data,
  output logic        fifo_empty,
  output logic        fifo_full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [PtrW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            empty_q, full_q;
  logic            rsp_valid_q;
  t_mmio_tid       rsp_tid_q;
  logic [63:0]     rsp_data_q;

  logic        wr_data_hit, wr_ctrl_hit, rd_data_hit;
  logic        push_ok, pop_ok, flush, clr;
  logic [63:0] ram_rdata, status_word, stats_word, rd_word;

  assign wr_data_hit = mmio_wr_valid && (mmio_wr_addr == DATA_ADDR);
  assign wr_ctrl_hit = mmio_wr_valid && (mmio_wr_addr == CTRL_ADDR);
  assign rd_data_hit = mmio_rd_valid && (mmio_rd_addr == DATA_ADDR);

  // A same-cycle successful pop frees the slot a push on a full FIFO needs.
  assign pop_ok  = rd_data_hit && (count_q != '0);
  assign push_ok = wr_data_hit && ((count_q != CntFull) || pop_ok);
  assign flush   = wr_ctrl_hit && mmio_wr_data[CtrlFlushBit];
  assign clr     = wr_ctrl_hit && mmio_wr_data[CtrlClearBit];

  mmio_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wp_q),
    .wdata (mmio_wr_data),
    .raddr (rp_q),
    .rdata (ram_rdata)
  );

  // Next-state pointers, occupancy and sticky flags; flag set beats clear.
  always_comb begin
    wp_d    = wp_q + PtrW'(push_ok);
    rp_d    = rp_q + PtrW'(pop_ok);
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end
    ovf_d = (wr_data_hit && !push_ok) || (ovf_q && !clr);
    unf_d = (rd_data_hit && !pop_ok) || (unf_q && !clr);
  end

  // Status word assembled from current (pre-update) state.
  always_comb begin
    status_word = '0;
    status_word[StatusCountLsb +: CntW] = count_q;
    status_word[StatusEmptyBit]         = empty_q;
    status_word[StatusFullBit]          = full_q;
    status_word[StatusOvfBit]           = ovf_q;
    status_word[StatusUnfBit]           = unf_q;
    status_word[StatusDepthLsb +: 32]   = DEPTH[31:0];
  end

`ifdef MMIO_FIFO_STATS_EN
  logic [31:0] push_cnt_q, pop_cnt_q;

  // Wrapping activity counters; a clear in the same cycle as a pop wins.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      push_cnt_q <= '0;
      pop_cnt_q  <= '0;
    end else begin
      push_cnt_q <= push_cnt_q + 32'(push_ok);
      pop_cnt_q  <= pop_cnt_q + 32'(pop_ok);
    end
  end

  assign stats_word = {pop_cnt_q, push_cnt_q};
`else
  assign stats_word = '0;
`endif

  // Read data mux; unmapped addresses still answer with zero.
  always_comb begin
    rd_word = '0;
    if (mmio_rd_addr == DATA_ADDR) begin
      rd_word = pop_ok ? ram_rdata : '0;
    end else if (mmio_rd_addr == STATUS_ADDR) begin
      rd_word = status_word;
    end else if (mmio_rd_addr == StatsAddr) begin
      rd_word = stats_word;
    end
  end

  // FIFO state, flags and the one-cycle read response register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      empty_q     <= (count_d == '0);
      full_q      <= (count_d == CntFull);
      rsp_valid_q <= mmio_rd_valid;
      if (mmio_rd_valid) begin
        rsp_tid_q  <= mmio_rd_tid;
        rsp_data_q <= rd_word;
      end
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_tid    = rsp_tid_q;
  assign rsp_data   = rsp_data_q;
  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Self-checking bench for mmio_fifo_ctrl: directed scenarios plus a random phase
// checked against a queue-based model of the register behaviour.
module tb_mmio_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam logic [15:0] A_DATA   = 16'h0020;
  localparam logic [15:0] A_STATUS = 16'h0022;
  localparam logic [15:0] A_CTRL   = 16'h0024;
  localparam logic [15:0] A_STATS  = 16'h0026;
  localparam logic [15:0] A_OTHER  = 16'h0030;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mmio_wr_valid = 1'b0;
  logic [15:0] mmio_wr_addr = '0;
  logic [63:0] mmio_wr_data = '0;
  logic        mmio_rd_valid = 1'b0;
  logic [15:0] mmio_rd_addr = '0;
  logic [8:0]  mmio_rd_tid = '0;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic        fifo_empty, fifo_full;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] mq[$];
  bit          m_ovf, m_unf;
  logic [31:0] m_push, m_pop;
  logic [63:0] last_data;
  logic [8:0]  last_tid;

  always #5 clk = ~clk;

  mmio_fifo_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mmio_wr_valid (mmio_wr_valid),
    .mmio_wr_addr  (mmio_wr_addr),
    .mmio_wr_data  (mmio_wr_data),
    .mmio_rd_valid (mmio_rd_valid),
    .mmio_rd_addr  (mmio_rd_addr),
    .mmio_rd_tid   (mmio_rd_tid),
    .rsp_valid     (rsp_valid),
    .rsp_tid       (rsp_tid),
    .rsp_data      (rsp_data),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_status();
    logic [63:0] s;
    s = '0;
    s[15:0]  = 16'(mq.size());
    s[16]    = (mq.size() == 0);
    s[17]    = (mq.size() == DEPTH);
    s[18]    = m_ovf;
    s[19]    = m_unf;
    s[63:32] = DEPTH;
    return s;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_ovf = 0; m_unf = 0; m_push = 0; m_pop = 0;
    last_data = '0; last_tid = '0;
  endtask

  // One clock cycle: drive strobes now (at a negedge), check at the next negedge.
  task automatic step(input bit we, input logic [15:0] wa, input logic [63:0] wd,
                      input bit re, input logic [15:0] ra, input logic [8:0] tid);
    logic [63:0] exp_d;
    bit          unf_set;
    mmio_wr_valid = we; mmio_wr_addr = wa; mmio_wr_data = wd;
    mmio_rd_valid = re; mmio_rd_addr = ra; mmio_rd_tid = tid;
    exp_d = '0;
    unf_set = 0;
    // Read observes pre-write state; the write then applies.
    if (re) begin
      if (ra == A_DATA) begin
        if (mq.size() > 0) begin
          exp_d = mq.pop_front();
          m_pop++;
        end else begin
          m_unf = 1;
          unf_set = 1;
        end
      end else if (ra == A_STATUS) begin
        exp_d = m_status();
      end else if (ra == A_STATS) begin
`ifdef MMIO_FIFO_STATS_EN
        exp_d = {m_pop, m_push};
`endif
      end
    end
    if (we) begin
      if (wa == A_DATA) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(wd);
          m_push++;
        end else begin
          m_ovf = 1;
        end
      end else if (wa == A_CTRL) begin
        if (wd[0]) mq.delete();
        if (wd[1]) begin
          m_ovf = 0; m_unf = unf_set; m_push = 0; m_pop = 0;
        end
      end
    end
    @(negedge clk);
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    check("rsp_valid", 64'(rsp_valid), 64'(re));
    if (re) begin
      check("rsp_tid", 64'(rsp_tid), 64'(tid));
      check("rsp_data", rsp_data, exp_d);
      last_data = exp_d;
      last_tid = tid;
    end else begin
      check("rsp_data_hold", rsp_data, last_data);
      check("rsp_tid_hold", 64'(rsp_tid), 64'(last_tid));
    end
    check("fifo_empty", 64'(fifo_empty), 64'(mq.size() == 0));
    check("fifo_full", 64'(fifo_full), 64'(mq.size() == DEPTH));
  endtask

  task automatic push(input logic [63:0] v);
    step(1, A_DATA, v, 0, A_DATA, 9'h0);
  endtask

  task automatic pop(input logic [8:0] tid);
    step(0, A_DATA, 64'h0, 1, A_DATA, tid);
  endtask

  task automatic rd(input logic [15:0] a, input logic [8:0] tid);
    step(0, A_DATA, 64'h0, 1, a, tid);
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    step(1, a, d, 0, A_DATA, 9'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_tid"}, 64'(rsp_tid), 64'd0);
    check({tag, "_rsp_data"}, rsp_data, 64'd0);
    check({tag, "_empty"}, 64'(fifo_empty), 64'd1);
    check({tag, "_full"}, 64'(fifo_full), 64'd0);
  endtask

  initial begin
    int r;
    logic [63:0] v;
    m_reset();

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Fill, then drain
    for (int i = 1; i <= 8; i++) push(64'(i));
    rd(A_STATUS, 9'h011);
    check("fill_count", 64'(rsp_data[15:0]), 64'd8);
    check("fill_full_bit", 64'(rsp_data[17]), 64'd1);
    check("fill_depth", 64'(rsp_data[63:32]), 64'd8);
    for (int i = 1; i <= 8; i++) begin
      pop(9'(i + 32));
      check("drain_value", rsp_data, 64'(i));
    end
    check("drain_empty", 64'(fifo_empty), 64'd1);

    // Overflow
    for (int i = 1; i <= 9; i++) push(64'(100 + i));
    rd(A_STATUS, 9'h012);
    check("ovf_bit", 64'(rsp_data[18]), 64'd1);
    wr(A_CTRL, 64'h2);
    rd(A_STATUS, 9'h013);
    check("ovf_clr_count", 64'(rsp_data[15:0]), 64'd8);
    check("ovf_clr_bit", 64'(rsp_data[18]), 64'd0);
    for (int i = 1; i <= 8; i++) pop(9'(i));

    // Underflow
    pop(9'h1A5);
    check("unf_tid", 64'(rsp_tid), 64'h1A5);
    check("unf_data", rsp_data, 64'd0);
    rd(A_STATUS, 9'h014);
    check("unf_bit", 64'(rsp_data[19]), 64'd1);
    check("unf_count", 64'(rsp_data[15:0]), 64'd0);
    wr(A_CTRL, 64'h2);

    // Wrap-around
    for (int i = 0; i < 5; i++) push(64'(200 + i));
    for (int i = 0; i < 5; i++) pop(9'(i));
    for (int i = 0; i < 8; i++) push(64'(300 + i));
    for (int i = 0; i < 8; i++) pop(9'(i));
    rd(A_STATUS, 9'h015);
    check("wrap_count", 64'(rsp_data[15:0]), 64'd0);

    // Flush
    for (int i = 0; i < 3; i++) push(64'(400 + i));
    wr(A_CTRL, 64'h1);
    rd(A_STATUS, 9'h016);
    check("flush_empty", 64'(rsp_data[16]), 64'd1);
    check("flush_count", 64'(rsp_data[15:0]), 64'd0);
    push(64'hDEAD);
    pop(9'h017);
    check("flush_first", rsp_data, 64'hDEAD);

    // Simultaneous events: push+pop on full, pop-on-empty with push, flush with pop
    for (int i = 0; i < 8; i++) push(64'(500 + i));
    step(1, A_DATA, 64'h5A5A, 1, A_DATA, 9'h020);
    step(1, A_CTRL, 64'h3, 1, A_DATA, 9'h021);
    step(1, A_DATA, 64'h77, 1, A_DATA, 9'h022);
    step(1, A_CTRL, 64'h2, 1, A_STATUS, 9'h023);
    pop(9'h024);

    // Back-to-back reads and CTRL/unmapped reads
    push(64'hA1); push(64'hA2);
    pop(9'h030); pop(9'h031); rd(A_CTRL, 9'h032); rd(16'h0040, 9'h033);
    wr(A_OTHER, 64'hFFFF);
    step(0, A_DATA, 64'h0, 0, A_DATA, 9'h0);

    // Stats
    wr(A_CTRL, 64'h3);
    for (int i = 0; i < 3; i++) push(64'(600 + i));
    pop(9'h040); pop(9'h041);
    rd(A_STATS, 9'h042);
`ifdef MMIO_FIFO_STATS_EN
    check("stats_word", rsp_data, {32'd2, 32'd3});
`else
    check("stats_word", rsp_data, 64'd0);
`endif

    // Random phase
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      v = {$urandom, $urandom};
      if (r < 35)      push(v);
      else if (r < 65) pop(9'($urandom));
      else if (r < 73) rd(A_STATUS, 9'($urandom));
      else if (r < 77) wr(A_CTRL, 64'($urandom_range(0, 3)));
      else if (r < 80) rd(A_CTRL, 9'($urandom));
      else if (r < 84) rd(A_STATS, 9'($urandom));
      else if (r < 87) wr(A_OTHER, v);
      else if (r < 90) rd(16'h0040, 9'($urandom));
      else if (r < 95) step(1, A_DATA, v, 1, A_DATA, 9'($urandom));
      else if (r < 98) step(1, A_CTRL, 64'($urandom_range(0, 3)), 1, A_DATA, 9'($urandom));
      else             step(0, A_DATA, 64'h0, 0, A_DATA, 9'h0);
    end

    // Reset mid-stream with a read in the reset cycle
    push(64'hBEEF); push(64'hCAFE);
    rst_n = 1'b0;
    mmio_rd_valid = 1'b1; mmio_rd_addr = A_DATA; mmio_rd_tid = 9'h0AA;
    @(negedge clk);
    mmio_rd_valid = 1'b0;
    rst_n = 1'b1;
    m_reset();
    check_reset_outputs("midrst");
    rd(A_STATUS, 9'h050);
    check("midrst_count", 64'(rsp_data[15:0]), 64'd0);
    pop(9'h051);
    check("midrst_pop", rsp_data, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
